axi4_stream_slave: RTL and testbench

AXI4-Stream slave that receives packets on a 128-bit stream, stores each packet in an internal 256-beat buffer, and, once `s_axis_tlast` is seen, writes one header word followed by the data beats into a 132-bit FIFO. The FIFO format is the one consumed by the team's `axi4_stream_master`: bits [9:0] hold the length in 32-bit words, with 0 meaning 1024; bit 10 holds tdest[0]; bit 12 holds tdest[1]; data words carry data in [127:0] and a keep nibble in [131:128]. This block forms the receive end of the board-to-board stream link.

---
 rtl/axi4_stream_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi4_stream_slave.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_slave.sv
// Receive end of the board-to-board stream link: buffers each AXI4-Stream packet and,
// once it is complete and legal, writes a length/tdest header plus its data beats into a 132-bit FIFO.
module axi4_stream_slave #(
  parameter int DATABUSWIDTH  = 16,
  parameter int TDESTWIDTH    = 2,
  parameter int FIFODATAWIDTH = 132,
  parameter int BUFDEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [8*DATABUSWIDTH-1:0] s_axis_tdata,
  input  logic [DATABUSWIDTH-1:0]  s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [TDESTWIDTH-1:0]    s_axis_tdest,
  output logic [FIFODATAWIDTH-1:0] fifo0_datain,
  output logic                     fifo0_wr_en,
  input  logic                     fifo0_full_flag,
  output logic                     pkt_done,
  output logic                     pkt_drop
);

  localparam int PW = $clog2(BUFDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    DISCARD = 2'd1,
    HDR     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [CW-1:0]            beat_cnt_r, beat_cnt_nxt_s;
  logic [CW-1:0]            rd_ptr_r, rd_ptr_nxt_s;
  logic [10:0]              words_r, words_nxt_s, beat_words_s;
  logic [TDESTWIDTH-1:0]    dest_r, dest_nxt_s, beat_dest_s;
  logic [FIFODATAWIDTH-1:0] datain_r, datain_nxt_s, mem_rd_s;
  logic                     tready_r, done_r, drop_r;
  logic                     done_nxt_s, drop_nxt_s;
  logic                     accept_s, wr_s, mem_we_s;
  logic                     keep_full_s, keep_half_s, keep_legal_s, buf_last_s;
  logic [FIFODATAWIDTH-1:0] buf_mem [BUFDEPTH];

  function automatic logic [3:0] keep_nibble(input logic [DATABUSWIDTH-1:0] keep);
    logic [3:0] nib;
    case (keep)
      16'hFFFF: nib = 4'b1111;
      16'h00FF: nib = 4'b0011;
      default:  nib = 4'b0000;
    endcase
    return nib;
  endfunction

  function automatic logic [FIFODATAWIDTH-1:0] header_word(input logic [TDESTWIDTH-1:0] dest,
                                                           input logic [9:0] len);
    logic [FIFODATAWIDTH-1:0] hdr;
    hdr      = {FIFODATAWIDTH{1'b0}};
    hdr[9:0] = len;
    hdr[10]  = dest[0];
    hdr[12]  = dest[1];
    return hdr;
  endfunction

  assign accept_s     = s_axis_tvalid & tready_r;
  assign wr_s         = ((state_r == HDR) | (state_r == DRAIN)) & ~fifo0_full_flag;
  assign keep_full_s  = (s_axis_tkeep == 16'hFFFF);
  assign keep_half_s  = (s_axis_tkeep == 16'h00FF);
  assign keep_legal_s = keep_full_s | (keep_half_s & s_axis_tlast);
  assign beat_words_s = words_r + (keep_full_s ? 11'd4 : 11'd2);
  assign beat_dest_s  = (beat_cnt_r == {CW{1'b0}}) ? s_axis_tdest : dest_r;
  assign buf_last_s   = (beat_cnt_r == CW'(BUFDEPTH - 1));
  assign mem_rd_s     = buf_mem[rd_ptr_r[PW-1:0]];

  assign s_axis_tready = tready_r;
  assign fifo0_wr_en   = wr_s;
  assign fifo0_datain  = datain_r;
  assign pkt_done      = done_r;
  assign pkt_drop      = drop_r;

  // Next-state, buffer bookkeeping and the FIFO word staged for the next write
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    words_nxt_s    = words_r;
    dest_nxt_s     = dest_r;
    datain_nxt_s   = datain_r;
    done_nxt_s     = 1'b0;
    drop_nxt_s     = 1'b0;
    mem_we_s       = 1'b0;
    case (state_r)
      RECV: begin
        if (accept_s) begin
          if (!keep_legal_s) begin
            beat_cnt_nxt_s = {CW{1'b0}};
            words_nxt_s    = 11'd0;
            if (s_axis_tlast) begin
              drop_nxt_s = 1'b1;
            end else begin
              state_nxt_s = DISCARD;
            end
          end else if (s_axis_tlast) begin
            mem_we_s       = 1'b1;
            beat_cnt_nxt_s = beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            words_nxt_s    = beat_words_s;
            dest_nxt_s     = beat_dest_s;
            rd_ptr_nxt_s   = {CW{1'b0}};
            datain_nxt_s   = header_word(beat_dest_s, beat_words_s[9:0]);
            state_nxt_s    = HDR;
          end else if (buf_last_s) begin
            beat_cnt_nxt_s = {CW{1'b0}};
            words_nxt_s    = 11'd0;
            state_nxt_s    = DISCARD;
          end else begin
            mem_we_s       = 1'b1;
            beat_cnt_nxt_s = beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            words_nxt_s    = beat_words_s;
            dest_nxt_s     = beat_dest_s;
          end
        end else begin
          state_nxt_s = RECV;
        end
      end
      DISCARD: begin
        if (accept_s && s_axis_tlast) begin
          drop_nxt_s  = 1'b1;
          state_nxt_s = RECV;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      HDR: begin
        if (wr_s) begin
          datain_nxt_s = mem_rd_s;
          rd_ptr_nxt_s = {{(CW-1){1'b0}}, 1'b1};
          state_nxt_s  = DRAIN;
        end else begin
          state_nxt_s = HDR;
        end
      end
      DRAIN: begin
        // rd_ptr_r counts beats already staged, so equality means the last beat is going out now
        if (wr_s && (rd_ptr_r == beat_cnt_r)) begin
          done_nxt_s     = 1'b1;
          beat_cnt_nxt_s = {CW{1'b0}};
          rd_ptr_nxt_s   = {CW{1'b0}};
          words_nxt_s    = 11'd0;
          datain_nxt_s   = {FIFODATAWIDTH{1'b0}};
          state_nxt_s    = RECV;
        end else if (wr_s) begin
          datain_nxt_s = mem_rd_s;
          rd_ptr_nxt_s = rd_ptr_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = RECV;
      end
    endcase
  end

  // Control registers; tready is registered from the next state so it has no input path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= RECV;
      beat_cnt_r <= {CW{1'b0}};
      rd_ptr_r   <= {CW{1'b0}};
      words_r    <= 11'd0;
      dest_r     <= {TDESTWIDTH{1'b0}};
      datain_r   <= {FIFODATAWIDTH{1'b0}};
      tready_r   <= 1'b0;
      done_r     <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      words_r    <= words_nxt_s;
      dest_r     <= dest_nxt_s;
      datain_r   <= datain_nxt_s;
      tready_r   <= (state_nxt_s == RECV) | (state_nxt_s == DISCARD);
      done_r     <= done_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  // Packet buffer, one {keep nibble, data} entry per accepted beat
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      buf_mem[beat_cnt_r[PW-1:0]] <= {keep_nibble(s_axis_tkeep), s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axi4_stream_slave.sv
// Directed and randomized bench for axi4_stream_slave against a packet-level reference model.
module tb_axi4_stream_slave;

  logic         clk;
  logic         reset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [1:0]   s_axis_tdest;
  logic [131:0] fifo0_datain;
  logic         fifo0_wr_en;
  logic         fifo0_full_flag;
  logic         pkt_done;
  logic         pkt_drop;

  int total = 0;
  int bad   = 0;

  logic [131:0] got_q[$];
  logic [131:0] exp_q[$];
  int ncyc = 0, nwr = 0, first_wr = 0, last_wr = 0, last_acc = 0;
  int done_cnt = 0, drop_cnt = 0, done_cyc = 0, drop_cyc = 0;
  int full_writes = 0, ready_writes = 0;
  logic ready_at_done = 1'b0;
  int full_mode = 0;
  bit gaps_en = 1'b0;

  logic [127:0] pk_data [300];
  logic [15:0]  pk_keep [300];
  logic [1:0]   pk_dest [300];

  axi4_stream_slave dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdest   (s_axis_tdest),
    .fifo0_datain   (fifo0_datain),
    .fifo0_wr_en    (fifo0_wr_en),
    .fifo0_full_flag(fifo0_full_flag),
    .pkt_done       (pkt_done),
    .pkt_drop       (pkt_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO full-flag generator: 0 never full, 1 toggles each cycle, 2 random
  initial begin
    fifo0_full_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        1:       fifo0_full_flag = ~fifo0_full_flag;
        2:       fifo0_full_flag = ($urandom_range(0, 3) == 0);
        default: fifo0_full_flag = 1'b0;
      endcase
    end
  end

  // Monitor: sampled mid-cycle, each event refers to the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (fifo0_wr_en) begin
        if (fifo0_full_flag) full_writes++;
        else begin
          got_q.push_back(fifo0_datain);
          if (nwr == 0) first_wr = ncyc;
          last_wr = ncyc;
          nwr++;
        end
        if (s_axis_tready) ready_writes++;
      end
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) last_acc = ncyc;
      if (pkt_done) begin
        done_cnt++;
        done_cyc = ncyc;
        ready_at_done = s_axis_tready;
      end
      if (pkt_drop) begin
        drop_cnt++;
        drop_cyc = ncyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_pkt(input int n, input bit last_half, input int bad_idx, input logic [15:0] bad_keep);
    for (int i = 0; i < n; i++) begin
      pk_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      pk_keep[i] = 16'hFFFF;
      pk_dest[i] = 2'($urandom_range(0, 3));
    end
    if (last_half) pk_keep[n-1] = 16'h00FF;
    if (bad_idx >= 0) pk_keep[bad_idx] = bad_keep;
  endtask

  // Reference: a packet is forwarded only if every beat is full-keep, except a half-keep
  // final beat, and it fits in 256 beats; otherwise it is dropped with no FIFO traffic.
  task automatic model_pkt(input int n, output bit legal);
    int words;
    logic [131:0] w;
    words = 0;
    legal = (n <= 256);
    for (int i = 0; i < n; i++) begin
      if (pk_keep[i] == 16'hFFFF) words += 4;
      else if (pk_keep[i] == 16'h00FF && i == n - 1) words += 2;
      else legal = 1'b0;
    end
    if (legal) begin
      w = 132'd0;
      w[9:0] = 10'(words % 1024);
      w[10]  = pk_dest[0][0];
      w[12]  = pk_dest[0][1];
      exp_q.push_back(w);
      for (int i = 0; i < n; i++)
        exp_q.push_back({(pk_keep[i] == 16'hFFFF) ? 4'b1111 : 4'b0011, pk_data[i]});
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [1:0] dst);
    int guard;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tdest  = dst;
    guard = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3000) begin
        chk("beat_accept_timeout", 132'(guard), 132'd0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps_en && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      send_beat(pk_data[i], pk_keep[i], (i == n - 1), pk_dest[i]);
    end
  endtask

  task automatic run_pkt(input string tag, input int n, input bit timed);
    bit legal;
    int done0, drop0, guard, m;
    got_q.delete();
    exp_q.delete();
    nwr = 0;
    full_writes = 0;
    ready_writes = 0;
    model_pkt(n, legal);
    done0 = done_cnt;
    drop0 = drop_cnt;
    send_pkt(n);
    guard = 0;
    while ((done_cnt + drop_cnt == done0 + drop0) && guard < 3000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    repeat (4) @(negedge clk);
    #2;
    chk({tag, " done_pulses"}, 132'(done_cnt - done0), legal ? 132'd1 : 132'd0);
    chk({tag, " drop_pulses"}, 132'(drop_cnt - drop0), legal ? 132'd0 : 132'd1);
    chk({tag, " write_count"}, 132'(got_q.size()), 132'(exp_q.size()));
    chk({tag, " writes_while_full"}, 132'(full_writes), 132'd0);
    chk({tag, " writes_while_ready"}, 132'(ready_writes), 132'd0);
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
    if (timed && legal) begin
      chk({tag, " hdr_latency"}, 132'(first_wr), 132'(last_acc + 1));
      chk({tag, " write_span"}, 132'(last_wr - first_wr), 132'(n));
      chk({tag, " done_timing"}, 132'(done_cyc), 132'(last_wr + 1));
      chk({tag, " ready_at_done"}, 132'(ready_at_done), 132'd1);
    end else if (timed) begin
      chk({tag, " drop_timing"}, 132'(drop_cyc), 132'(last_acc + 1));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] bad_keeps [4];
    int n, guard;
    bit legal;
    bad_keeps[0] = 16'h0000;
    bad_keeps[1] = 16'h000F;
    bad_keeps[2] = 16'hFF00;
    bad_keeps[3] = 16'h7FFF;

    reset = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 128'd0;
    s_axis_tkeep = 16'd0;
    s_axis_tlast = 1'b0;
    s_axis_tdest = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tready", 132'(s_axis_tready), 132'd0);
    chk("rst wr_en", 132'(fifo0_wr_en), 132'd0);
    chk("rst datain", fifo0_datain, 132'd0);
    chk("rst done", 132'(pkt_done), 132'd0);
    chk("rst drop", 132'(pkt_drop), 132'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rel tready_before_edge", 132'(s_axis_tready), 132'd0);
    @(posedge clk);
    #1;
    chk("rel tready_after_edge", 132'(s_axis_tready), 132'd1);

    build_pkt(1, 1'b1, -1, 16'h0);
    pk_dest[0] = 2'b11;
    run_pkt("p1beat", 1, 1'b1);
    chk("p1beat hdr_const", (got_q.size() > 0) ? got_q[0] : 132'hX, 132'h1402);

    build_pkt(5, 1'b0, -1, 16'h0);
    pk_dest[0] = 2'b01;
    run_pkt("p5beat", 5, 1'b1);
    chk("p5beat hdr_const", (got_q.size() > 0) ? got_q[0] : 132'hX, 132'h414);

    build_pkt(256, 1'b0, -1, 16'h0);
    run_pkt("p256", 256, 1'b1);
    chk("p256 len_zero", (got_q.size() > 0) ? 132'(got_q[0][9:0]) : 132'hX, 132'd0);

    build_pkt(258, 1'b0, -1, 16'h0);
    run_pkt("p258_drop", 258, 1'b1);

    full_mode = 1;
    build_pkt(8, 1'b0, -1, 16'h0);
    run_pkt("p8_fulltoggle", 8, 1'b0);
    full_mode = 0;
    @(posedge clk);
    #1;

    build_pkt(4, 1'b0, 1, 16'h00FF);
    run_pkt("p4_halfmid", 4, 1'b1);
    build_pkt(3, 1'b1, -1, 16'h0);
    run_pkt("p3_after_drop", 3, 1'b1);

    build_pkt(1, 1'b0, 0, 16'h0F0F);
    run_pkt("p1_badlast", 1, 1'b1);

    // Reset during drain of a 10-beat packet, after three FIFO writes
    got_q.delete();
    exp_q.delete();
    nwr = 0;
    build_pkt(10, 1'b0, -1, 16'h0);
    model_pkt(10, legal);
    send_pkt(10);
    guard = 0;
    while (nwr < 3 && guard < 200) begin
      @(negedge clk);
      #2;
      guard++;
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rstdrain wr_en", 132'(fifo0_wr_en), 132'd0);
    chk("rstdrain tready", 132'(s_axis_tready), 132'd0);
    chk("rstdrain datain", fifo0_datain, 132'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rstdrain tready_before_edge", 132'(s_axis_tready), 132'd0);
    @(posedge clk);
    #1;
    chk("rstdrain tready_after_edge", 132'(s_axis_tready), 132'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("rstdrain writes", 132'(got_q.size()), 132'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("rstdrain word%0d", i), got_q[i], exp_q[i]);
    @(posedge clk);
    #1;

    gaps_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(1, 24);
      full_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      if ($urandom_range(0, 4) == 0)
        build_pkt(n, 1'b0, $urandom_range(0, n - 1), bad_keeps[$urandom_range(0, 3)]);
      else
        build_pkt(n, $urandom_range(0, 1) == 1, -1, 16'h0);
      run_pkt($sformatf("rnd%0d", p), n, full_mode == 0);
      full_mode = 0;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
